// File: rtl/ad9228_pkg.sv
// Shared types and constants for the AD9228 frame-aligning deserializer.
package ad9228_pkg;

    // Alignment state machine states.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    // Default word geometry (12-bit AD9228 samples, two bits per DCO edge).
    localparam int unsigned DEFAULT_DATA_WIDTH = 12;
    localparam int unsigned PAIRS_PER_WORD     = DEFAULT_DATA_WIDTH / 2;
    localparam int unsigned MAX_DATA_WIDTH     = 16;

    // FCO word: width/2 ones (earliest bits) followed by width/2 zeros,
    // right-aligned in a MAX_DATA_WIDTH vector.
    function automatic logic [MAX_DATA_WIDTH-1:0] fco_pattern(input int unsigned width);
        logic [MAX_DATA_WIDTH-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
            p[i] = (i >= width / 2) && (i < width);
        end
        return p;
    endfunction

endpackage

// File: rtl/ad9228_lane_shifter.sv
// One serial lane: optional polarity inversion, bit history and
// word-window extraction at a one-bit offset selected by half.
module ad9228_lane_shifter
    import ad9228_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic        INVERT     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            pair_in,
    input  logic                  half,
    output logic [DATA_WIDTH-1:0] window
);

    logic [DATA_WIDTH:0] hist_q;
    logic [DATA_WIDTH:0] hist_d;

    // Shift the (possibly inverted) pair in; newest bit lands in the LSB.
    always_comb begin
        hist_d = {hist_q[DATA_WIDTH-2:0], pair_in ^ {2{INVERT}}};
    end

    // History register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // half=1 looks one bit further back in time.
    always_comb begin
        window = half ? hist_q[DATA_WIDTH:1] : hist_q[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/ad9228_framer.sv
// Frame-aligning deserializer for AD9228-style serial LVDS ADCs.
// Finds the word boundary from the FCO lane by bit-granular slipping and
// emits aligned parallel samples for all lanes once locked.
module ad9228_framer
    import ad9228_pkg::*;
#(
    parameter int unsigned     NUM_CH     = 4,
    parameter int unsigned     DATA_WIDTH = 12,
    parameter int unsigned     LOCK_COUNT = 16,
    parameter int unsigned     MISS_LIMIT = 2,
    parameter logic [NUM_CH:0] INV_MASK   = '0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [2*NUM_CH-1:0]            din_pair,
    input  logic [1:0]                     fco_pair,
    output logic [NUM_CH*DATA_WIDTH-1:0]   data_out,
    output logic                           data_valid,
    output logic                           locked,
    output logic                           frame_err,
    output logic [$clog2(DATA_WIDTH)-1:0]  slip_count
);

    localparam int unsigned PAIRS = DATA_WIDTH / 2;
    localparam int unsigned SW    = $clog2(DATA_WIDTH);
    localparam int unsigned PHW   = SW - 1;
    localparam int unsigned GW    = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MW    = $clog2(MISS_LIMIT + 1);

    localparam logic [PHW-1:0]        PH_LAST     = PHW'(PAIRS - 1);
    localparam logic [GW-1:0]         LOCK_CNT_L  = GW'(LOCK_COUNT);
    localparam logic [MW-1:0]         MISS_LIM_L  = MW'(MISS_LIMIT);
    localparam logic [DATA_WIDTH-1:0] FCO_PATTERN = DATA_WIDTH'(fco_pattern(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] lane_win [NUM_CH];
    logic [DATA_WIDTH-1:0] fco_win;

    align_state_t                  state_q, state_d;
    logic [PHW-1:0]                ph_q, ph_d;
    logic                          half_q, half_d;
    logic [PHW-1:0]                stall_q, stall_d;
    logic                          skip_q, skip_d;
    logic [GW-1:0]                 good_q, good_d;
    logic [MW-1:0]                 miss_q, miss_d;
    logic [NUM_CH*DATA_WIDTH-1:0]  data_q, data_d;
    logic                          valid_q, valid_d;
    logic                          err_q, err_d;

    logic boundary;
    logic compare;
    logic match;
    logic slip;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        ad9228_lane_shifter #(
            .DATA_WIDTH (DATA_WIDTH),
            .INVERT     (INV_MASK[gi])
        ) u_lane (
            .clk     (clk),
            .rstn    (rstn),
            .pair_in (din_pair[2*gi+1:2*gi]),
            .half    (half_q),
            .window  (lane_win[gi])
        );
    end

    ad9228_lane_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .INVERT     (INV_MASK[NUM_CH])
    ) u_fco (
        .clk     (clk),
        .rstn    (rstn),
        .pair_in (fco_pair),
        .half    (half_q),
        .window  (fco_win)
    );

    // Alignment FSM, phase/offset bookkeeping and output capture.
    always_comb begin
        state_d = state_q;
        ph_d    = (ph_q == PH_LAST) ? '0 : ph_q + PHW'(1);
        half_d  = half_q;
        stall_d = stall_q;
        skip_d  = skip_q;
        good_d  = good_q;
        miss_d  = miss_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        slip    = 1'b0;

        boundary = (ph_q == PH_LAST);
        compare  = boundary && !skip_q;
        match    = (fco_win == FCO_PATTERN);

        if (boundary && skip_q) begin
            skip_d = 1'b0;
        end

        if (compare) begin
            unique case (state_q)
                SEARCH: begin
                    if (match) begin
                        if (LOCK_COUNT == 1) begin
                            state_d = LOCKED;
                        end else begin
                            state_d = VERIFY;
                            good_d  = GW'(1);
                        end
                    end else begin
                        slip = 1'b1;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        good_d = good_q + GW'(1);
                        if (good_q + GW'(1) == LOCK_CNT_L) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end
                    end else begin
                        err_d   = 1'b1;
                        slip    = 1'b1;
                        good_d  = '0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (miss_q + MW'(1) == MISS_LIM_L) begin
                            miss_d  = '0;
                            slip    = 1'b1;
                            state_d = SEARCH;
                        end else begin
                            miss_d = miss_q + MW'(1);
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase

            if (state_d == LOCKED) begin
                valid_d = 1'b1;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    data_d[DATA_WIDTH*i +: DATA_WIDTH] = lane_win[i];
                end
            end
        end

        // A pair stall holds ph at the boundary value for one extra cycle;
        // that repeated boundary is the one consumed by skip, so the next
        // compared boundary sees a fully refilled window.
        if (slip) begin
            skip_d = 1'b1;
            if (!half_q) begin
                half_d = 1'b1;
            end else begin
                half_d  = 1'b0;
                ph_d    = ph_q;
                stall_d = (stall_q == PH_LAST) ? '0 : stall_q + PHW'(1);
            end
        end
    end

    // State and output registers. skip starts set so the partially filled
    // history seen at the first boundary after reset is never compared.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SEARCH;
            ph_q    <= '0;
            half_q  <= 1'b0;
            stall_q <= '0;
            skip_q  <= 1'b1;
            good_q  <= '0;
            miss_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            half_q  <= half_d;
            stall_q <= stall_d;
            skip_q  <= skip_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Output mapping.
    always_comb begin
        data_out   = data_q;
        data_valid = valid_q;
        frame_err  = err_q;
        locked     = (state_q == LOCKED);
        slip_count = {stall_q, half_q};
    end

endmodule

// File: tb/tb_ad9228_framer.sv
// Self-checking bench for ad9228_framer: random-offset ramp streams, FCO
// glitches, lock loss/relock and mid-frame reset, checked every cycle
// against a frame-level reference model.
module tb_ad9228_framer;

    localparam int NCH  = 4;
    localparam int W    = 12;
    localparam int P    = W / 2;
    localparam int LC   = 4;
    localparam int ML   = 2;
    localparam int MAXE = 2048;
    localparam logic [NCH:0] INV = 5'b10010;
    localparam logic [W-1:0] FCO = 12'b111111_000000;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [2*NCH-1:0]   din_pair = '0;
    logic [1:0]         fco_pair = '0;
    logic [NCH*W-1:0]   data_out;
    logic               data_valid;
    logic               locked;
    logic               frame_err;
    logic [3:0]         slip_count;

    ad9228_framer #(
        .NUM_CH     (NCH),
        .DATA_WIDTH (W),
        .LOCK_COUNT (LC),
        .MISS_LIMIT (ML),
        .INV_MASK   (INV)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_pair   (din_pair),
        .fco_pair   (fco_pair),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .frame_err  (frame_err),
        .slip_count (slip_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stream configuration: bit delay, ramp base, FCO words to corrupt.
    int dly  = 0;
    int base = 0;
    bit bad_word [0:511];

    // Logical (pre-inversion) bits sent since reset release.
    bit rec [0:NCH][0:2*MAXE-1];
    int e = 0;

    // Reference model state.
    int m_state, m_good, m_miss, m_half, m_stalls, m_next;
    logic [W-1:0] exp_data [NCH];
    bit exp_valid, exp_err;

    // Observations used by the literal pins.
    bit seen_lock, lock_dropped;
    int first_lock_e, lock_slip, err_pulses, valid_pulses;
    logic [W-1:0] first_data [NCH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word n of the source stream starts at bit 10+12n (+dly); word ends then
    // coincide with the first compared boundary when no slip is needed.
    function automatic logic [W-1:0] src_word(input int lane, input int w);
        if (lane == NCH) return bad_word[w + 2] ? ~FCO : FCO;
        return W'(256 * lane + w + base);
    endfunction

    function automatic bit src_bit(input int lane, input int t);
        int q;
        logic [W-1:0] wv;
        q  = t - dly + 14;
        wv = src_word(lane, q / 12 - 2);
        return wv[W - 1 - (q % 12)];
    endfunction

    // Word formed from the recorded stream when c pairs have arrived,
    // looking h bits back.
    function automatic logic [W-1:0] rec_win(input int lane, input int c, input int h);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[W-1-k] = rec[lane][2*c - W - h + k];
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_good = 0; m_miss = 0; m_half = 0; m_stalls = 0;
        m_next = 2 * P - 1;
        exp_valid = 0; exp_err = 0;
        for (int i = 0; i < NCH; i++) exp_data[i] = '0;
    endtask

    // Frame-level model: decisions happen only at scheduled compare points.
    task automatic model_step(input int c);
        bit match, slip;
        exp_valid = 0; exp_err = 0;
        if (c == m_next) begin
            match = (rec_win(NCH, c, m_half) == FCO);
            slip  = 0;
            case (m_state)
                0: if (match) begin m_state = 1; m_good = 1; if (m_good == LC) m_state = 2; end
                   else slip = 1;
                1: if (match) begin m_good++; if (m_good == LC) m_state = 2; end
                   else begin exp_err = 1; slip = 1; m_state = 0; end
                default: if (match) m_miss = 0;
                   else begin
                       exp_err = 1; m_miss++;
                       if (m_miss == ML) begin m_miss = 0; slip = 1; m_state = 0; end
                   end
            endcase
            if (slip && m_half == 0) begin
                m_half = 1; m_next = c + 2 * P;
            end else if (slip) begin
                m_half = 0; m_stalls = (m_stalls + 1) % P; m_next = c + 1 + P;
            end else begin
                m_next = c + P;
            end
            if (m_state == 2) begin
                exp_valid = 1;
                for (int i = 0; i < NCH; i++) exp_data[i] = rec_win(i, c, m_half);
            end
        end
    endtask

    task automatic drive(input int ed);
        bit b0, b1;
        for (int i = 0; i <= NCH; i++) begin
            b0 = src_bit(i, 2 * ed);
            b1 = src_bit(i, 2 * ed + 1);
            rec[i][2*ed]   = b0;
            rec[i][2*ed+1] = b1;
            if (i < NCH) begin
                din_pair[2*i+1] = b0 ^ INV[i];
                din_pair[2*i]   = b1 ^ INV[i];
            end else begin
                fco_pair = {b0 ^ INV[NCH], b1 ^ INV[NCH]};
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data_out"},   64'(data_out),   64'd0);
        chk({tag, "_data_valid"}, 64'(data_valid), 64'd0);
        chk({tag, "_locked"},     64'(locked),     64'd0);
        chk({tag, "_frame_err"},  64'(frame_err),  64'd0);
        chk({tag, "_slip_count"}, 64'(slip_count), 64'd0);
    endtask

    // Compare process: outputs sampled on the falling edge after each edge.
    always @(negedge clk) begin
        logic [NCH*W-1:0] exp_bus;
        if (!rstn) begin
            chk_zero("reset");
            model_reset();
            e = 0;
            drive(0);
        end else begin
            model_step(e);
            for (int i = 0; i < NCH; i++) exp_bus[W*i +: W] = exp_data[i];
            chk("data_valid", 64'(data_valid), 64'(exp_valid));
            chk("frame_err",  64'(frame_err),  64'(exp_err));
            chk("locked",     64'(locked),     64'(m_state == 2));
            chk("slip_count", 64'(slip_count), 64'(2 * m_stalls + m_half));
            chk("data_out",   64'(data_out),   64'(exp_bus));
            if (locked && !seen_lock) begin
                seen_lock = 1; first_lock_e = e; lock_slip = int'(slip_count);
                for (int i = 0; i < NCH; i++) first_data[i] = data_out[W*i +: W];
            end
            if (seen_lock && !locked) lock_dropped = 1;
            err_pulses   += int'(frame_err);
            valid_pulses += int'(data_valid);
            e++;
            if (e >= MAXE - 1) begin
                errors++;
                $display("FAIL run_length: got %0d edges expected below %0d", e, MAXE - 1);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $fatal(1, "run too long");
            end
            drive(e);
        end
    end

    task automatic clear_obs();
        seen_lock = 0; lock_dropped = 0; first_lock_e = -1; lock_slip = -1;
        err_pulses = 0; valid_pulses = 0;
    endtask

    task automatic start_run(input int d, input int b);
        @(posedge clk); #1;
        rstn = 1'b0;
        dly = d; base = b;
        for (int i = 0; i < 512; i++) bad_word[i] = 0;
        @(negedge clk);
        @(negedge clk); #1;
        rstn = 1'b1;
        clear_obs();
    endtask

    task automatic wait_lock(input string tag, input int budget);
        int n = 0;
        while (!seen_lock && n < budget) begin @(negedge clk); #1; n++; end
        chk({tag, "_lock_timeout"}, 64'(seen_lock), 64'd1);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    // Index of the word compared at the boundary reached after c pairs
    // when aligned; used to place corruptions a few frames ahead.
    function automatic int word_at(input int c);
        return (2 * c - 1 - dly + 14) / 12 - 2;
    endfunction

    initial begin
        int wg, n, d;
        for (int i = 0; i < 512; i++) bad_word[i] = 0;
        clear_obs();
        repeat (3) @(negedge clk);
        #1;
        chk_zero("por");

        // Aligned stream from reset.
        start_run(0, 0);
        wait_lock("aligned", 300);
        chk("aligned_lock_edge", 64'(first_lock_e), 64'd29);
        chk("aligned_slip", 64'(lock_slip), 64'd0);
        for (int i = 0; i < NCH; i++) chk("aligned_first_word", 64'(first_data[i]), 64'(256 * i + 3));
        run_cycles(30);
        chk("aligned_no_err", 64'(err_pulses), 64'd0);

        // Single FCO glitch while locked.
        wg = word_at(e) + 3;
        bad_word[wg + 2] = 1;
        err_pulses = 0; valid_pulses = 0;
        run_cycles(60);
        chk("glitch_err_pulses", 64'(err_pulses), 64'd1);
        chk("glitch_stay_locked", 64'(lock_dropped), 64'd0);
        chk("glitch_valid_continues", 64'(valid_pulses >= 9), 64'd1);

        // Two consecutive bad frames drop lock; clean FCO then relocks.
        wg = word_at(e) + 3;
        bad_word[wg + 2] = 1;
        bad_word[wg + 3] = 1;
        n = 0;
        while (!lock_dropped && n < 60) begin @(negedge clk); #1; n++; end
        chk("loss_lock_dropped", 64'(lock_dropped), 64'd1);
        seen_lock = 0; valid_pulses = 0;
        wait_lock("relock", 400);
        chk("relock_slip_wrap", 64'(lock_slip), 64'd0);
        chk("relock_single_valid", 64'(valid_pulses), 64'd1);

        // Reset asserted at ph=3 while locked.
        n = 0;
        while (!data_valid && n < 20) begin @(negedge clk); #1; n++; end
        chk("midreset_saw_valid", 64'(data_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        #1 chk_zero("midreset");
        dly = 2 * $urandom_range(0, 5); base = $urandom_range(0, 4095);
        @(negedge clk);
        @(negedge clk); #1;
        rstn = 1'b1;
        clear_obs();
        wait_lock("midreset_relock", 400);
        chk("midreset_slip", 64'(lock_slip), 64'(dly));
        run_cycles(20);

        // Offset sweep with random ramp bases and occasional glitches.
        for (int k = 0; k < W; k++) begin
            d = k;
            start_run(d, $urandom_range(0, 4095));
            wait_lock("sweep", 400);
            if (d % 2 == 0) chk("sweep_even_slip", 64'(lock_slip), 64'(d));
            if ($urandom_range(0, 1) == 1) begin
                wg = word_at(e + 6 * int'(slip_count)) + 2;
                run_cycles(6);
                err_pulses = 0;
                lock_dropped = 0;
                bad_word[word_at(e) + 4] = 1;
                run_cycles(48);
                chk("sweep_glitch_err", 64'(err_pulses), 64'd1);
                chk("sweep_glitch_locked", 64'(lock_dropped), 64'd0);
            end else begin
                run_cycles(36);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
